// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: op fields, size codes,
// exception codes and FSM states.
package lsu_pkg;

    // req_op bit positions
    localparam int unsigned OP_STORE    = 3;
    localparam int unsigned OP_UNSIGNED = 2;

    // req_op[1:0] access size
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_t;

    // exc_code values
    localparam logic [1:0] EXC_TIMEOUT = 2'b00;
    localparam logic [1:0] EXC_ADEL    = 2'b01;
    localparam logic [1:0] EXC_ADES    = 2'b10;
    localparam logic [1:0] EXC_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    function automatic size_t op_size(input logic [3:0] op);
        return size_t'(op[1:0]);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for a big-endian 32-bit data memory:
// store side builds byte enables, replicated data and a misalign flag;
// load side extracts and extends the addressed byte/half.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [3:0]  st_op,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  be,
    output logic [31:0] lane_data,
    output logic        misalign,
    input  logic [3:0]  ld_op,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store side: enables and replicated data from size and offset
    always_comb begin
        be        = '0;
        lane_data = st_data;
        misalign  = 1'b0;
        case (op_size(st_op))
            SZ_BYTE: begin
                be        = 4'b1000 >> st_off;
                lane_data = {4{st_data[7:0]}};
            end
            SZ_HALF: begin
                be        = st_off[1] ? 4'b0011 : 4'b1100;
                lane_data = {2{st_data[15:0]}};
                misalign  = st_off[0];
            end
            SZ_WORD: begin
                be        = 4'b1111;
                misalign  = (st_off != 2'b00);
            end
            default: begin
                be        = '0;
            end
        endcase
    end

    // Load side: pick the addressed lane (offset 0 is the MSB byte) and extend
    always_comb begin
        case (ld_off)
            2'd0:    ld_byte = rdata[31:24];
            2'd1:    ld_byte = rdata[23:16];
            2'd2:    ld_byte = rdata[15:8];
            default: ld_byte = rdata[7:0];
        endcase
        ld_half = ld_off[1] ? rdata[15:0] : rdata[31:16];
        case (op_size(ld_op))
            SZ_BYTE: ld_data = ld_op[OP_UNSIGNED] ? {24'b0, ld_byte}
                                                  : {{24{ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = ld_op[OP_UNSIGNED] ? {16'b0, ld_half}
                                                  : {{16{ld_half[15]}}, ld_half};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: accepts one request, drives the data memory
// strobes until mem_ready or timeout, then reports a load result or exception.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exc_valid,
    output logic [1:0]  exc_code,
    output logic [31:0] exc_badvaddr
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t        state;
    logic [3:0]    op_q;
    logic [31:0]   addr_q;
    logic [4:0]    rd_q;
    logic [CW-1:0] cnt;

    logic [3:0]    be_c;
    logic [31:0]   lane_c;
    logic          misalign_c;
    logic [31:0]   ld_data_c;
    logic          illegal_c;

    // Store lanes come from the live request (registered at accept);
    // load extraction uses the latched op/offset while in ACCESS.
    lsu_lane_align u_align (
        .st_op     (req_op),
        .st_off    (req_addr[1:0]),
        .st_data   (req_wdata),
        .be        (be_c),
        .lane_data (lane_c),
        .misalign  (misalign_c),
        .ld_op     (op_q),
        .ld_off    (addr_q[1:0]),
        .rdata     (mem_rdata),
        .ld_data   (ld_data_c)
    );

    // Illegal size detection at accept
    always_comb begin
        illegal_c = (op_size(req_op) == SZ_ILL);
    end

    // Ready is decoded from state so it is high out of reset
    assign req_ready = (state == ST_IDLE);

    // Request FSM with timeout counter and registered strobes/results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            op_q         <= '0;
            addr_q       <= '0;
            rd_q         <= '0;
            cnt          <= '0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            exc_valid    <= 1'b0;
            exc_code     <= '0;
            exc_badvaddr <= '0;
        end else begin
            wb_valid  <= 1'b0;
            exc_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q      <= req_op;
                        addr_q    <= req_addr;
                        rd_q      <= req_rd;
                        cnt       <= '0;
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        mem_be    <= be_c;
                        mem_wdata <= lane_c;
                        if (illegal_c) begin
                            exc_valid    <= 1'b1;
                            exc_code     <= EXC_ILLEGAL;
                            exc_badvaddr <= req_addr;
                            state        <= ST_RESP;
                        end else if (misalign_c) begin
                            exc_valid    <= 1'b1;
                            exc_code     <= req_op[OP_STORE] ? EXC_ADES : EXC_ADEL;
                            exc_badvaddr <= req_addr;
                            state        <= ST_RESP;
                        end else begin
                            mem_read  <= ~req_op[OP_STORE];
                            mem_write <= req_op[OP_STORE];
                            state     <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    // mem_ready is checked first so it wins over a coincident timeout
                    if (mem_ready) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (!op_q[OP_STORE]) begin
                            wb_valid <= 1'b1;
                            wb_data  <= ld_data_c;
                            wb_rd    <= rd_q;
                        end
                        state <= ST_RESP;
                    end else if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
                        mem_read     <= 1'b0;
                        mem_write    <= 1'b0;
                        exc_valid    <= 1'b1;
                        exc_code     <= EXC_TIMEOUT;
                        exc_badvaddr <= addr_q;
                        state        <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (TIMEOUT=4).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_valid;
    logic [1:0]  exc_code;
    logic [31:0] exc_badvaddr;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rd       (req_rd),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .exc_valid    (exc_valid),
        .exc_code     (exc_code),
        .exc_badvaddr (exc_badvaddr)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for exactly one accept edge
    task automatic issue(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        req_rd    = rd;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        req_rd = '0; mem_ready = 1'b0; mem_rdata = '0;
        tick(); tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b want 1", req_ready); end
        checks++; if ({mem_read, mem_write, wb_valid, exc_valid} !== 4'b0000) begin errors++; $display("FAIL rst_strobes got %b want 0000", {mem_read, mem_write, wb_valid, exc_valid}); end
        checks++; if ({mem_addr, mem_be, wb_data, exc_code} !== '0) begin errors++; $display("FAIL rst_regs got %h %h %h %h want 0", mem_addr, mem_be, wb_data, exc_code); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_store_word();
        mem_ready = 1'b1;
        issue(4'b1010, 32'h10, 32'h11223344, 5'd0);
        checks++; if ({mem_write, mem_read} !== 2'b10) begin errors++; $display("FAIL sw_strobe got %b want 10", {mem_write, mem_read}); end
        checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL sw_addr got %h want 00000010", mem_addr); end
        checks++; if (mem_be !== 4'b1111) begin errors++; $display("FAIL sw_be got %b want 1111", mem_be); end
        checks++; if (mem_wdata !== 32'h11223344) begin errors++; $display("FAIL sw_wdata got %h want 11223344", mem_wdata); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL sw_busy got %0b want 0", req_ready); end
        tick();
        checks++; if ({wb_valid, exc_valid, mem_write} !== 3'b000) begin errors++; $display("FAIL sw_resp got %b want 000", {wb_valid, exc_valid, mem_write}); end
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL sw_idle got %0b want 1", req_ready); end
    endtask

    task automatic test_loads();
        // lb 0x13: be=0001, byte 3 = 0xF0 sign-extended
        mem_ready = 1'b1; mem_rdata = 32'h000000F0;
        issue(4'b0000, 32'h13, '0, 5'd7);
        checks++; if ({mem_read, mem_write} !== 2'b10) begin errors++; $display("FAIL lb_strobe got %b want 10", {mem_read, mem_write}); end
        checks++; if (mem_be !== 4'b0001 || mem_addr !== 32'h10) begin errors++; $display("FAIL lb_be_addr got %b %h want 0001 00000010", mem_be, mem_addr); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL lb_early got %0b want 0", wb_valid); end
        tick();
        checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hFFFFFFF0 || wb_rd !== 5'd7) begin errors++; $display("FAIL lb_wb got %0b %h %0d want 1 fffffff0 7", wb_valid, wb_data, wb_rd); end
        tick();
        checks++; if (wb_valid !== 1'b0 || wb_data !== 32'hFFFFFFF0) begin errors++; $display("FAIL lb_pulse got %0b %h want 0 fffffff0", wb_valid, wb_data); end
        // lbu 0x13
        issue(4'b0100, 32'h13, '0, 5'd8);
        tick();
        checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h000000F0) begin errors++; $display("FAIL lbu_wb got %0b %h want 1 000000f0", wb_valid, wb_data); end
        tick();
        // lh 0x12: lower half sign-extended
        mem_rdata = 32'h00008001;
        issue(4'b0001, 32'h12, '0, 5'd9);
        checks++; if (mem_be !== 4'b0011) begin errors++; $display("FAIL lh_be got %b want 0011", mem_be); end
        tick();
        checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hFFFF8001) begin errors++; $display("FAIL lh_wb got %0b %h want 1 ffff8001", wb_valid, wb_data); end
        tick();
    endtask

    task automatic test_store_half();
        mem_ready = 1'b1;
        issue(4'b1001, 32'h06, 32'h0000ABCD, 5'd0);
        checks++; if (mem_addr !== 32'h04 || mem_be !== 4'b0011) begin errors++; $display("FAIL sh_addr_be got %h %b want 00000004 0011", mem_addr, mem_be); end
        checks++; if (mem_wdata !== 32'hABCDABCD || mem_write !== 1'b1) begin errors++; $display("FAIL sh_wdata got %h %0b want abcdabcd 1", mem_wdata, mem_write); end
        tick(); tick();
        // sb offset 1 -> be 0100, byte replicated
        issue(4'b1000, 32'h21, 32'h000000A5, 5'd0);
        checks++; if (mem_be !== 4'b0100 || mem_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_lane got %b %h want 0100 a5a5a5a5", mem_be, mem_wdata); end
        tick(); tick();
    endtask

    task automatic test_faults();
        logic seen;
        mem_ready = 1'b1;
        req_valid = 1'b1; req_op = 4'b0010; req_addr = 32'h02; req_rd = 5'd3;
        seen = 1'b0;
        tick();
        req_valid = 1'b0;
        seen = seen | mem_read;
        checks++; if (exc_valid !== 1'b1 || exc_code !== 2'b01 || exc_badvaddr !== 32'h02) begin errors++; $display("FAIL lw_adel got %0b %b %h want 1 01 00000002", exc_valid, exc_code, exc_badvaddr); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL lw_adel_wb got %0b want 0", wb_valid); end
        tick();
        seen = seen | mem_read;
        checks++; if (seen !== 1'b0 || exc_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL lw_adel_after got rd=%0b exc=%0b rdy=%0b want 0 0 1", seen, exc_valid, req_ready); end
        issue(4'b1001, 32'h01, 32'h1234, 5'd0);
        checks++; if (exc_valid !== 1'b1 || exc_code !== 2'b10 || mem_write !== 1'b0) begin errors++; $display("FAIL sh_ades got %0b %b %0b want 1 10 0", exc_valid, exc_code, mem_write); end
        tick();
        issue(4'b0011, 32'h40, '0, 5'd0);
        checks++; if (exc_valid !== 1'b1 || exc_code !== 2'b11 || exc_badvaddr !== 32'h40) begin errors++; $display("FAIL illegal got %0b %b %h want 1 11 00000040", exc_valid, exc_code, exc_badvaddr); end
        tick();
    endtask

    task automatic test_timeout();
        int high;
        bit done;
        mem_ready = 1'b0;
        issue(4'b0010, 32'h20, '0, 5'd4);
        high = 0; done = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            if (mem_read) begin
                high++;
                tick();
            end else begin
                done = 1'b1;
            end
        end
        checks++; if (!done || high != 4) begin errors++; $display("FAIL to_cycles got %0d want 4", high); end
        checks++; if (exc_valid !== 1'b1 || exc_code !== 2'b00 || exc_badvaddr !== 32'h20 || wb_valid !== 1'b0) begin errors++; $display("FAIL to_exc got %0b %b %h wb=%0b want 1 00 00000020 0", exc_valid, exc_code, exc_badvaddr, wb_valid); end
        tick();
        // mem_ready on the 4th ACCESS cycle completes normally
        issue(4'b0010, 32'h24, '0, 5'd5);
        tick(); tick(); tick();
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL to_edge_strobe got %0b want 1", mem_read); end
        mem_ready = 1'b1; mem_rdata = 32'h12345678;
        tick();
        checks++; if (wb_valid !== 1'b1 || exc_valid !== 1'b0 || wb_data !== 32'h12345678 || wb_rd !== 5'd5) begin errors++; $display("FAIL to_edge_done got %0b %0b %h %0d want 1 0 12345678 5", wb_valid, exc_valid, wb_data, wb_rd); end
        tick();
    endtask

    task automatic test_reset_mid_access();
        logic pulse;
        mem_ready = 1'b0;
        issue(4'b0010, 32'h40, '0, 5'd6);
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL mid_pre got %0b want 1", mem_read); end
        #2 rst = 1'b1;
        #1;
        checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL mid_async got %0b %0b %0b want 0 0 1", mem_read, mem_write, req_ready); end
        tick();
        rst = 1'b0;
        mem_ready = 1'b1;
        pulse = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulse = pulse | wb_valid | exc_valid;
            tick();
        end
        checks++; if (pulse !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL mid_quiet got pulse=%0b rdy=%0b want 0 1", pulse, req_ready); end
        mem_rdata = 32'h00AB0000;
        issue(4'b0100, 32'h41, '0, 5'd2);
        tick();
        checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h000000AB || wb_rd !== 5'd2) begin errors++; $display("FAIL mid_next got %0b %h %0d want 1 000000ab 2", wb_valid, wb_data, wb_rd); end
        tick();
    endtask

    task automatic test_back_to_back();
        mem_ready = 1'b1; mem_rdata = 32'h80550000;
        req_valid = 1'b1; req_op = 4'b0000; req_addr = 32'h0; req_rd = 5'd1;
        tick();
        checks++; if (req_ready !== 1'b0 || mem_read !== 1'b1) begin errors++; $display("FAIL b2b_access got rdy=%0b rd=%0b want 0 1", req_ready, mem_read); end
        tick();
        checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hFFFFFF80 || req_ready !== 1'b0) begin errors++; $display("FAIL b2b_first got %0b %h rdy=%0b want 1 ffffff80 0", wb_valid, wb_data, req_ready); end
        tick();
        req_addr = 32'h1; req_rd = 5'd2;
        checks++; if (req_ready !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL b2b_idle got rdy=%0b rd=%0b want 1 0", req_ready, mem_read); end
        tick();
        req_valid = 1'b0;
        tick();
        checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h00000055 || wb_rd !== 5'd2) begin errors++; $display("FAIL b2b_second got %0b %h %0d want 1 00000055 2", wb_valid, wb_data, wb_rd); end
        tick();
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_loads();
        test_store_half();
        test_faults();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
